// File: rtl/game_pkg.sv
// Shared definitions for the guessing-game datapath: count width and the
// encoding of the end-of-round result presented to the display stage.
package game_pkg;

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    RES_PLAY = 2'b00,
    RES_WIN  = 2'b01,
    RES_LOSE = 2'b10,
    RES_DRAW = 2'b11
  } result_e;

endpackage : game_pkg

// File: rtl/decision_classify.sv
// Combinational classifier: turns the correct/wrong guess counts and the two
// inclusive thresholds into a game-state class, draw taking priority.
module decision_classify
  import game_pkg::*;
(
  input  logic [CNT_W-1:0] i_correct,
  input  logic [CNT_W-1:0] i_wrong,
  input  logic [CNT_W-1:0] i_win_thr,
  input  logic [CNT_W-1:0] i_lose_thr,
  output result_e          o_class
);

  logic w_win_hit;
  logic w_lose_hit;

  assign w_win_hit  = (i_correct >= i_win_thr);
  assign w_lose_hit = (i_wrong   >= i_lose_thr);

  always_comb begin
    // NOTE: default assignment first so every path drives o_class -- no latch.
    o_class = RES_PLAY;
    if (w_win_hit && w_lose_hit) begin
      o_class = RES_DRAW;
    end else if (w_win_hit) begin
      o_class = RES_WIN;
    end else if (w_lose_hit) begin
      o_class = RES_LOSE;
    end
  end

endmodule : decision_classify

// File: rtl/decision_unit.sv
// End-of-round arbiter: registers the classified game state with one cycle of
// latency, optionally freezing the first decided (non-PLAY) result until reset.
module decision_unit
  import game_pkg::*;
#(
  parameter int WIN_COUNT  = 3,
  parameter int LOSE_COUNT = 3,
  parameter bit STICKY     = 1'b0
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [CNT_W-1:0] Out_wr,
  input  logic [CNT_W-1:0] Correct_guess,
  output logic [1:0]       Result
);

  if (WIN_COUNT < 1 || WIN_COUNT > 3) begin : g_bad_win_count
    $error("decision_unit: WIN_COUNT=%0d outside legal range 1..3", WIN_COUNT);
  end
  if (LOSE_COUNT < 1 || LOSE_COUNT > 3) begin : g_bad_lose_count
    $error("decision_unit: LOSE_COUNT=%0d outside legal range 1..3", LOSE_COUNT);
  end

  localparam logic [CNT_W-1:0] WIN_THR  = CNT_W'(WIN_COUNT);
  localparam logic [CNT_W-1:0] LOSE_THR = CNT_W'(LOSE_COUNT);

  result_e w_class;
  result_e w_next;
  logic    w_hold;
  result_e r_result;

  decision_classify u_classify (
    .i_correct  (Correct_guess),
    .i_wrong    (Out_wr),
    .i_win_thr  (WIN_THR),
    .i_lose_thr (LOSE_THR),
    .o_class    (w_class)
  );

  // In sticky mode the result register itself is the latch: once it leaves
  // PLAY it only reloads through reset, so WIN/LOSE can never become DRAW.
  assign w_hold = STICKY && (r_result != RES_PLAY);
  assign w_next = w_hold ? r_result : w_class;

  // NOTE: async reset clears the only state flop here; non-blocking for all state.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_result <= RES_PLAY;
    end else begin
      r_result <= w_next;
    end
  end

  assign Result = r_result;

endmodule : decision_unit

// File: tb/tb_decision_unit.sv
// Self-checking bench for decision_unit: three instances (plain, sticky, and
// low thresholds) share stimulus and are compared against an arithmetic model.
module tb_decision_unit;

  logic       Clock;
  logic       Reset_n;
  logic [1:0] Out_wr;
  logic [1:0] Correct_guess;
  logic [1:0] res_plain;
  logic [1:0] res_sticky;
  logic [1:0] res_low;

  logic [1:0] exp_plain;
  logic [1:0] exp_sticky;
  logic [1:0] exp_low;

  int n_cmp = 0;
  int n_err = 0;

  decision_unit #(.WIN_COUNT(3), .LOSE_COUNT(3), .STICKY(1'b0)) u_plain (
    .Clock(Clock), .Reset_n(Reset_n), .Out_wr(Out_wr),
    .Correct_guess(Correct_guess), .Result(res_plain)
  );

  decision_unit #(.WIN_COUNT(3), .LOSE_COUNT(3), .STICKY(1'b1)) u_sticky (
    .Clock(Clock), .Reset_n(Reset_n), .Out_wr(Out_wr),
    .Correct_guess(Correct_guess), .Result(res_sticky)
  );

  decision_unit #(.WIN_COUNT(2), .LOSE_COUNT(1), .STICKY(1'b0)) u_low (
    .Clock(Clock), .Reset_n(Reset_n), .Out_wr(Out_wr),
    .Correct_guess(Correct_guess), .Result(res_low)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Win contributes bit 0 and lose contributes bit 1, so both together is DRAW.
  function automatic logic [1:0] model_class(input int c, input int w,
                                             input int wt, input int lt);
    int r;
    r = 0;
    if (c >= wt) r = r + 1;
    if (w >= lt) r = r + 2;
    return r[1:0];
  endfunction

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/plain"},  res_plain,  exp_plain);
    check({tag, "/sticky"}, res_sticky, exp_sticky);
    check({tag, "/low"},    res_low,    exp_low);
  endtask

  task automatic model_reset();
    exp_plain  = 2'b00;
    exp_sticky = 2'b00;
    exp_low    = 2'b00;
  endtask

  // Drive inputs, take one edge per cycle, advance the model, check 1 ns later.
  task automatic apply(input logic [1:0] c, input logic [1:0] w,
                       input int cycles, input string tag);
    for (int k = 0; k < cycles; k++) begin
      Correct_guess = c;
      Out_wr        = w;
      @(posedge Clock);
      exp_plain = model_class(int'(c), int'(w), 3, 3);
      exp_low   = model_class(int'(c), int'(w), 2, 1);
      if (exp_sticky == 2'b00) exp_sticky = model_class(int'(c), int'(w), 3, 3);
      #1;
      check_all(tag);
    end
  endtask

  // Mid-cycle reset pulse: Result must clear before any clock edge arrives.
  task automatic reset_pulse(input string tag);
    #3;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n       = 1'b1;
    Correct_guess = 2'b11;
    Out_wr        = 2'b00;
    model_reset();

    #2;
    Reset_n = 1'b0;
    #1;
    check_all("reset_async");
    repeat (2) begin
      @(posedge Clock);
      #1;
      check_all("reset_hold");
    end
    @(negedge Clock);
    Reset_n = 1'b1;
    apply(2'b11, 2'b00, 1, "reset_release");

    // Reset asserted mid-cycle while a WIN is registered.
    reset_pulse("reset_midcycle");

    // Below thresholds for the default instances.
    apply(2'b01, 2'b10, 2, "below_a");
    apply(2'b10, 2'b01, 2, "below_b");

    // Win, held, then back to play (sticky instance keeps WIN).
    apply(2'b11, 2'b01, 5, "win_hold");
    apply(2'b00, 2'b01, 1, "win_drop");

    // Lose on the plain instance; sticky stays frozen on WIN.
    apply(2'b00, 2'b11, 1, "lose");
    apply(2'b00, 2'b00, 1, "lose_drop");

    // Sticky WIN must survive until reset, never upgraded to DRAW.
    apply(2'b11, 2'b11, 2, "sticky_no_upgrade");
    reset_pulse("sticky_clear");

    // DRAW from PLAY is latched as DRAW in sticky mode.
    apply(2'b11, 2'b11, 1, "draw");
    apply(2'b00, 2'b00, 2, "draw_after");
    reset_pulse("draw_clear");

    // Sticky LOSE held against later win input.
    apply(2'b00, 2'b11, 1, "sticky_lose");
    apply(2'b11, 2'b00, 2, "sticky_lose_hold");
    reset_pulse("sticky_lose_clear");

    // All 16 input pairs, in both sweep orders.
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        apply(2'(c), 2'(w), 1, "sweep_cw");
    for (int w = 0; w < 4; w++)
      for (int c = 3; c >= 0; c--)
        apply(2'(c), 2'(w), 1, "sweep_wc");

    // Random stimulus with occasional mid-cycle reset pulses.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15) == 0) reset_pulse("rand_reset");
      apply(2'($urandom_range(3)), 2'($urandom_range(3)),
            int'($urandom_range(2, 1)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_decision_unit
